// File: rtl/decode_stage_pipe_pkg.sv
// Shared types for the pipelined decode stage: control enums, RV32I opcodes and the
// packed control word carried in the ID/EX register.
package decode_stage_pipe_pkg;

    typedef enum logic [1:0] {
        WbAlu = 2'd0,
        WbMem = 2'd1,
        WbPc4 = 2'd2
    } wb_sel_e;

    typedef enum logic [3:0] {
        AluAdd   = 4'd0,
        AluSub   = 4'd1,
        AluSll   = 4'd2,
        AluSlt   = 4'd3,
        AluSltu  = 4'd4,
        AluXor   = 4'd5,
        AluSrl   = 4'd6,
        AluSra   = 4'd7,
        AluOr    = 4'd8,
        AluAnd   = 4'd9,
        AluPassB = 4'd10
    } alu_op_e;

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;

    // alu_src1: 0 = rs1, 1 = pc.  alu_src2: 0 = rs2, 1 = immediate.
    typedef struct packed {
        wb_sel_e wb_sel;
        logic    mem_read;
        logic    mem_write;
        logic    jump;
        logic    branch;
        logic    reg_write;
        alu_op_e alu_op;
        logic    alu_src1;
        logic    alu_src2;
        logic    illegal;
    } id_ex_ctrl_t;

    // funct7[5] selects SUB only for register-register ops; SRA/SRAI use it in both forms.
    function automatic alu_op_e alu_from_funct(input logic [2:0] funct3, input logic f7b5,
                                               input logic is_reg);
        alu_op_e op;
        case (funct3)
            3'b000:  op = (is_reg && f7b5) ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = f7b5 ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/register_file.sv
// Two-read, one-write register file; x0 is hard-wired to zero and reads bypass a
// same-cycle write-back.
module register_file #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic [REG_ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr1,
    output logic [DATA_WIDTH-1:0]     rd_data1,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr2,
    output logic [DATA_WIDTH-1:0]     rd_data2
);

    localparam int unsigned NumRegs = 2 ** REG_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NumRegs];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (wr_addr != '0)) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data1 = regs_q[rd_addr1];
        if (rd_addr1 == '0) begin
            rd_data1 = '0;
        end else if (we && (wr_addr == rd_addr1)) begin
            rd_data1 = wr_data;
        end
    end

    always_comb begin
        rd_data2 = regs_q[rd_addr2];
        if (rd_addr2 == '0) begin
            rd_data2 = '0;
        end else if (we && (wr_addr == rd_addr2)) begin
            rd_data2 = wr_data;
        end
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// RV32I decode stage with register read, load-use bubble insertion and ID/EX register.
// Optional performance counters are built when DECODE_PERF_CNT_EN is defined.
module decode_stage_pipe
    import decode_stage_pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      IF_valid_i,
    input  logic [31:0]               IF_instruction_i,
    input  logic [DATA_WIDTH-1:0]     IF_pc_i,
    output logic                      ID_ready_o,
    input  logic                      WB_we_i,
    input  logic [REG_ADDR_WIDTH-1:0] WB_wr_addr_i,
    input  logic [DATA_WIDTH-1:0]     WB_wr_data_i,
    input  logic                      EX_flush_i,
    input  logic                      EX_ready_i,
    output logic                      EX_valid_o,
    output wb_sel_e                   EX_WBSel_o,
    output logic                      EX_MemRead_o,
    output logic                      EX_MemWrite_o,
    output logic                      EX_Jump_o,
    output logic                      EX_Branch_o,
    output logic                      EX_RegWrite_o,
    output alu_op_e                   EX_ALUOp_o,
    output logic                      EX_ALUOpSrc1_o,
    output logic                      EX_ALUOpSrc2_o,
    output logic                      EX_illegal_o,
    output logic [DATA_WIDTH-1:0]     EX_pc_o,
    output logic [DATA_WIDTH-1:0]     EX_rd_data1_o,
    output logic [DATA_WIDTH-1:0]     EX_rd_data2_o,
    output logic [DATA_WIDTH-1:0]     EX_imm_o,
    output logic [REG_ADDR_WIDTH-1:0] EX_rs1_addr_o,
    output logic [REG_ADDR_WIDTH-1:0] EX_rs2_addr_o,
    output logic [REG_ADDR_WIDTH-1:0] EX_rd_addr_o,
    output logic [31:0]               ID_stall_cnt_o,
    output logic [31:0]               ID_flush_cnt_o
);

    logic [6:0]                opcode;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr, rs2_addr, rd_addr;
    logic [DATA_WIDTH-1:0]     rs1_data, rs2_data, imm;
    logic [31:0]               imm32;
    id_ex_ctrl_t               dec_ctrl;
    logic                      rs1_used, rs2_used;
    logic                      hazard, advance;

    assign opcode   = IF_instruction_i[6:0];
    assign rs1_addr = REG_ADDR_WIDTH'(IF_instruction_i[19:15]);
    assign rs2_addr = REG_ADDR_WIDTH'(IF_instruction_i[24:20]);
    assign rd_addr  = REG_ADDR_WIDTH'(IF_instruction_i[11:7]);
    assign imm      = DATA_WIDTH'($signed(imm32));

    always_comb begin
        dec_ctrl = '0;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        imm32    = '0;
        case (opcode)
            OpcOp: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_op    = alu_from_funct(IF_instruction_i[14:12],
                                                    IF_instruction_i[30], 1'b1);
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            OpcOpImm: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src2  = 1'b1;
                dec_ctrl.alu_op    = alu_from_funct(IF_instruction_i[14:12],
                                                    IF_instruction_i[30], 1'b0);
                rs1_used = 1'b1;
                imm32    = {{20{IF_instruction_i[31]}}, IF_instruction_i[31:20]};
            end
            OpcLoad: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.mem_read  = 1'b1;
                dec_ctrl.wb_sel    = WbMem;
                dec_ctrl.alu_src2  = 1'b1;
                rs1_used = 1'b1;
                imm32    = {{20{IF_instruction_i[31]}}, IF_instruction_i[31:20]};
            end
            OpcStore: begin
                dec_ctrl.mem_write = 1'b1;
                dec_ctrl.alu_src2  = 1'b1;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                imm32    = {{20{IF_instruction_i[31]}}, IF_instruction_i[31:25],
                            IF_instruction_i[11:7]};
            end
            OpcBranch: begin
                dec_ctrl.branch = 1'b1;
                dec_ctrl.alu_op = AluSub;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                imm32    = {{19{IF_instruction_i[31]}}, IF_instruction_i[31], IF_instruction_i[7],
                            IF_instruction_i[30:25], IF_instruction_i[11:8], 1'b0};
            end
            OpcJal: begin
                dec_ctrl.jump      = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.wb_sel    = WbPc4;
                dec_ctrl.alu_src1  = 1'b1;
                dec_ctrl.alu_src2  = 1'b1;
                imm32 = {{11{IF_instruction_i[31]}}, IF_instruction_i[31],
                         IF_instruction_i[19:12], IF_instruction_i[20],
                         IF_instruction_i[30:21], 1'b0};
            end
            OpcJalr: begin
                dec_ctrl.jump      = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.wb_sel    = WbPc4;
                dec_ctrl.alu_src2  = 1'b1;
                rs1_used = 1'b1;
                imm32    = {{20{IF_instruction_i[31]}}, IF_instruction_i[31:20]};
            end
            OpcLui: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_op    = AluPassB;
                dec_ctrl.alu_src2  = 1'b1;
                imm32 = {IF_instruction_i[31:12], 12'b0};
            end
            OpcAuipc: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src1  = 1'b1;
                dec_ctrl.alu_src2  = 1'b1;
                imm32 = {IF_instruction_i[31:12], 12'b0};
            end
            default: begin
                dec_ctrl.illegal = 1'b1;
            end
        endcase
    end

    register_file #(
        .DATA_WIDTH    (DATA_WIDTH),
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_register_file (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (WB_we_i),
        .wr_addr (WB_wr_addr_i),
        .wr_data (WB_wr_data_i),
        .rd_addr1(rs1_addr),
        .rd_data1(rs1_data),
        .rd_addr2(rs2_addr),
        .rd_data2(rs2_data)
    );

    logic                      ex_valid_q;
    id_ex_ctrl_t               ex_ctrl_q;
    logic [DATA_WIDTH-1:0]     ex_pc_q, ex_rd1_q, ex_rd2_q, ex_imm_q;
    logic [REG_ADDR_WIDTH-1:0] ex_rs1_q, ex_rs2_q, ex_rd_q;

    assign hazard = ex_valid_q && ex_ctrl_q.mem_read && (ex_rd_q != '0) &&
                    (((ex_rd_q == rs1_addr) && rs1_used) || ((ex_rd_q == rs2_addr) && rs2_used));
    assign advance    = EX_ready_i || !ex_valid_q;
    assign ID_ready_o = EX_flush_i || (advance && !hazard);

    // Control is cleared whenever valid drops so EX never needs to qualify it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
            ex_pc_q    <= '0;
            ex_rd1_q   <= '0;
            ex_rd2_q   <= '0;
            ex_imm_q   <= '0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
            ex_rd_q    <= '0;
        end else if (EX_flush_i || (advance && hazard)) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
        end else if (advance) begin
            ex_valid_q <= IF_valid_i;
            ex_ctrl_q  <= IF_valid_i ? dec_ctrl : '0;
            ex_pc_q    <= IF_pc_i;
            ex_rd1_q   <= rs1_data;
            ex_rd2_q   <= rs2_data;
            ex_imm_q   <= imm;
            ex_rs1_q   <= rs1_addr;
            ex_rs2_q   <= rs2_addr;
            ex_rd_q    <= rd_addr;
        end
    end

    assign EX_valid_o     = ex_valid_q;
    assign EX_WBSel_o     = ex_ctrl_q.wb_sel;
    assign EX_MemRead_o   = ex_ctrl_q.mem_read;
    assign EX_MemWrite_o  = ex_ctrl_q.mem_write;
    assign EX_Jump_o      = ex_ctrl_q.jump;
    assign EX_Branch_o    = ex_ctrl_q.branch;
    assign EX_RegWrite_o  = ex_ctrl_q.reg_write;
    assign EX_ALUOp_o     = ex_ctrl_q.alu_op;
    assign EX_ALUOpSrc1_o = ex_ctrl_q.alu_src1;
    assign EX_ALUOpSrc2_o = ex_ctrl_q.alu_src2;
    assign EX_illegal_o   = ex_ctrl_q.illegal;
    assign EX_pc_o        = ex_pc_q;
    assign EX_rd_data1_o  = ex_rd1_q;
    assign EX_rd_data2_o  = ex_rd2_q;
    assign EX_imm_o       = ex_imm_q;
    assign EX_rs1_addr_o  = ex_rs1_q;
    assign EX_rs2_addr_o  = ex_rs2_q;
    assign EX_rd_addr_o   = ex_rd_q;

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;
    logic        bubble;

    assign bubble = !EX_flush_i && advance && hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (bubble && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (EX_flush_i && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign ID_stall_cnt_o = stall_cnt_q;
    assign ID_flush_cnt_o = flush_cnt_q;
`else
    assign ID_stall_cnt_o = '0;
    assign ID_flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Scoreboard bench for decode_stage_pipe: expected ID/EX records are queued as instructions
// are presented and compared when the stage hands them to EX.
module tb_decode_stage_pipe;
    import decode_stage_pipe_pkg::*;

`ifdef DECODE_PERF_CNT_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    typedef struct packed {
        logic        valid;
        id_ex_ctrl_t ctrl;
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  rs1, rs2, rd;
    } ex_rec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        IF_valid_i;
    logic [31:0] IF_instruction_i, IF_pc_i;
    logic        ID_ready_o;
    logic        WB_we_i;
    logic [4:0]  WB_wr_addr_i;
    logic [31:0] WB_wr_data_i;
    logic        EX_flush_i, EX_ready_i, EX_valid_o;
    wb_sel_e     EX_WBSel_o;
    alu_op_e     EX_ALUOp_o;
    logic        EX_MemRead_o, EX_MemWrite_o, EX_Jump_o, EX_Branch_o, EX_RegWrite_o;
    logic        EX_ALUOpSrc1_o, EX_ALUOpSrc2_o, EX_illegal_o;
    logic [31:0] EX_pc_o, EX_rd_data1_o, EX_rd_data2_o, EX_imm_o;
    logic [4:0]  EX_rs1_addr_o, EX_rs2_addr_o, EX_rd_addr_o;
    logic [31:0] ID_stall_cnt_o, ID_flush_cnt_o;

    int          checks = 0;
    int          failures = 0;
    int          stall_events = 0;
    int          flush_events = 0;
    logic [31:0] ref_regs [32];
    ex_rec_t     sb [$];
    ex_rec_t     got, exp_r;

    always #5 clk = ~clk;

    decode_stage_pipe #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .IF_valid_i(IF_valid_i), .IF_instruction_i(IF_instruction_i), .IF_pc_i(IF_pc_i),
        .ID_ready_o(ID_ready_o),
        .WB_we_i(WB_we_i), .WB_wr_addr_i(WB_wr_addr_i), .WB_wr_data_i(WB_wr_data_i),
        .EX_flush_i(EX_flush_i), .EX_ready_i(EX_ready_i), .EX_valid_o(EX_valid_o),
        .EX_WBSel_o(EX_WBSel_o), .EX_MemRead_o(EX_MemRead_o), .EX_MemWrite_o(EX_MemWrite_o),
        .EX_Jump_o(EX_Jump_o), .EX_Branch_o(EX_Branch_o), .EX_RegWrite_o(EX_RegWrite_o),
        .EX_ALUOp_o(EX_ALUOp_o), .EX_ALUOpSrc1_o(EX_ALUOpSrc1_o),
        .EX_ALUOpSrc2_o(EX_ALUOpSrc2_o), .EX_illegal_o(EX_illegal_o),
        .EX_pc_o(EX_pc_o), .EX_rd_data1_o(EX_rd_data1_o), .EX_rd_data2_o(EX_rd_data2_o),
        .EX_imm_o(EX_imm_o), .EX_rs1_addr_o(EX_rs1_addr_o), .EX_rs2_addr_o(EX_rs2_addr_o),
        .EX_rd_addr_o(EX_rd_addr_o),
        .ID_stall_cnt_o(ID_stall_cnt_o), .ID_flush_cnt_o(ID_flush_cnt_o)
    );

    function automatic ex_rec_t observe();
        ex_rec_t r;
        r.valid          = EX_valid_o;
        r.ctrl.wb_sel    = EX_WBSel_o;
        r.ctrl.mem_read  = EX_MemRead_o;
        r.ctrl.mem_write = EX_MemWrite_o;
        r.ctrl.jump      = EX_Jump_o;
        r.ctrl.branch    = EX_Branch_o;
        r.ctrl.reg_write = EX_RegWrite_o;
        r.ctrl.alu_op    = EX_ALUOp_o;
        r.ctrl.alu_src1  = EX_ALUOpSrc1_o;
        r.ctrl.alu_src2  = EX_ALUOpSrc2_o;
        r.ctrl.illegal   = EX_illegal_o;
        r.pc  = EX_pc_o;
        r.rd1 = EX_rd_data1_o;
        r.rd2 = EX_rd_data2_o;
        r.imm = EX_imm_o;
        r.rs1 = EX_rs1_addr_o;
        r.rs2 = EX_rs2_addr_o;
        r.rd  = EX_rd_addr_o;
        return r;
    endfunction

    function automatic id_ex_ctrl_t ctl(wb_sel_e wb, logic mr, logic mw, logic j, logic b,
                                        logic rw, alu_op_e op, logic s1, logic s2, logic ill);
        id_ex_ctrl_t c;
        c.wb_sel = wb; c.mem_read = mr; c.mem_write = mw; c.jump = j; c.branch = b;
        c.reg_write = rw; c.alu_op = op; c.alu_src1 = s1; c.alu_src2 = s2; c.illegal = ill;
        return c;
    endfunction

    // Expected record; register data comes from the bench's own register model.
    function automatic ex_rec_t mk(logic [31:0] instr, logic [31:0] pc, logic [31:0] imm,
                                   id_ex_ctrl_t c);
        ex_rec_t r;
        r.valid = 1'b1;
        r.ctrl  = c;
        r.pc    = pc;
        r.rs1   = instr[19:15];
        r.rs2   = instr[24:20];
        r.rd    = instr[11:7];
        r.rd1   = ref_regs[instr[19:15]];
        r.rd2   = ref_regs[instr[24:20]];
        r.imm   = imm;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc);
        IF_valid_i       = 1'b1;
        IF_instruction_i = instr;
        IF_pc_i          = pc;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        WB_we_i = 1'b1; WB_wr_addr_i = a; WB_wr_data_i = d;
        tick();
        WB_we_i = 1'b0;
        if (a != 5'd0) ref_regs[a] = d;
    endtask

    task automatic test_reset();
        checks++;
        if (observe() !== ex_rec_t'(0)) begin
            failures++;
            $display("FAIL reset_outputs: got %h required 0", observe());
        end
        checks++;
        if ({ID_stall_cnt_o, ID_flush_cnt_o} !== 64'd0) begin
            failures++;
            $display("FAIL reset_counters: got %h/%h required 0/0", ID_stall_cnt_o, ID_flush_cnt_o);
        end
    endtask

    task automatic test_rtype();
        wb_write(5'd1, 32'd100);
        wb_write(5'd2, 32'd200);
        EX_ready_i = 1'b1;
        present(32'h002081b3, 32'h100);
        sb.push_back(mk(32'h002081b3, 32'h100, 32'd0,
                        ctl(WbAlu, 0, 0, 0, 0, 1, AluAdd, 0, 0, 0)));
        @(negedge clk);
        checks++;
        if (ID_ready_o !== 1'b1) begin
            failures++; $display("FAIL rtype_ready: got %b required 1", ID_ready_o);
        end
        tick();
        IF_valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (sb.size() == 0) begin
            failures++; $display("FAIL rtype_payload: scoreboard empty");
        end else begin
            exp_r = sb.pop_front(); got = observe();
            if (got !== exp_r) begin
                failures++; $display("FAIL rtype_payload: got %h required %h", got, exp_r);
            end
        end
        tick();
        @(negedge clk);
        checks++;
        if ({EX_valid_o, EX_RegWrite_o} !== 2'b00) begin
            failures++; $display("FAIL rtype_drain: got %b required 00", {EX_valid_o, EX_RegWrite_o});
        end
    endtask

    task automatic test_bypass();
        tick();
        WB_we_i = 1'b1; WB_wr_addr_i = 5'd1; WB_wr_data_i = 32'd7;
        present(32'h03208213, 32'h104);
        exp_r = mk(32'h03208213, 32'h104, 32'd50, ctl(WbAlu, 0, 0, 0, 0, 1, AluAdd, 0, 1, 0));
        exp_r.rd1 = 32'd7;
        sb.push_back(exp_r);
        tick();
        WB_we_i = 1'b0; IF_valid_i = 1'b0;
        ref_regs[1] = 32'd7;
        @(negedge clk);
        checks++;
        if (sb.size() == 0) begin
            failures++; $display("FAIL bypass_payload: scoreboard empty");
        end else begin
            exp_r = sb.pop_front(); got = observe();
            if (got !== exp_r) begin
                failures++; $display("FAIL bypass_payload: got %h required %h", got, exp_r);
            end
        end
    endtask

    task automatic test_load_use();
        tick();
        present(32'h0080a283, 32'h108);
        sb.push_back(mk(32'h0080a283, 32'h108, 32'd8,
                        ctl(WbMem, 1, 0, 0, 0, 1, AluAdd, 0, 1, 0)));
        tick();
        present(32'h00228333, 32'h10c);
        sb.push_back(mk(32'h00228333, 32'h10c, 32'd0,
                        ctl(WbAlu, 0, 0, 0, 0, 1, AluAdd, 0, 0, 0)));
        @(negedge clk);
        checks++;
        if (sb.size() == 0) begin
            failures++; $display("FAIL load_payload: scoreboard empty");
        end else begin
            exp_r = sb.pop_front(); got = observe();
            if (got !== exp_r) begin
                failures++; $display("FAIL load_payload: got %h required %h", got, exp_r);
            end
        end
        checks++;
        if (ID_ready_o !== 1'b0) begin
            failures++; $display("FAIL load_use_stall: ID_ready got %b required 0", ID_ready_o);
        end
        tick();
        stall_events++;
        @(negedge clk);
        checks++;
        if ({EX_valid_o, EX_MemRead_o, EX_RegWrite_o, ID_ready_o} !== 4'b0001) begin
            failures++;
            $display("FAIL load_use_bubble: valid/memrd/regwr/ready got %b required 0001",
                     {EX_valid_o, EX_MemRead_o, EX_RegWrite_o, ID_ready_o});
        end
        tick();
        IF_valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (sb.size() == 0) begin
            failures++; $display("FAIL load_use_issue: scoreboard empty");
        end else begin
            exp_r = sb.pop_front(); got = observe();
            if (got !== exp_r) begin
                failures++; $display("FAIL load_use_issue: got %h required %h", got, exp_r);
            end
        end
        checks++;
        if (ID_stall_cnt_o !== (PerfEn ? 32'(stall_events) : 32'd0)) begin
            failures++;
            $display("FAIL stall_cnt: got %0d required %0d", ID_stall_cnt_o,
                     PerfEn ? stall_events : 0);
        end
    endtask

    task automatic test_flush();
        tick();
        present(32'h00208863, 32'h110);
        EX_flush_i = 1'b1;
        @(negedge clk);
        checks++;
        if (ID_ready_o !== 1'b1) begin
            failures++; $display("FAIL flush_ready: got %b required 1", ID_ready_o);
        end
        tick();
        flush_events++;
        EX_flush_i = 1'b0; IF_valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({EX_valid_o, EX_Branch_o} !== 2'b00) begin
            failures++; $display("FAIL flush_kill: valid/branch got %b required 00",
                                 {EX_valid_o, EX_Branch_o});
        end
        checks++;
        if (ID_flush_cnt_o !== (PerfEn ? 32'(flush_events) : 32'd0)) begin
            failures++;
            $display("FAIL flush_cnt: got %0d required %0d", ID_flush_cnt_o,
                     PerfEn ? flush_events : 0);
        end
    endtask

    task automatic test_backpressure();
        tick();
        present(32'h0020a623, 32'h114);
        sb.push_back(mk(32'h0020a623, 32'h114, 32'd12,
                        ctl(WbAlu, 0, 1, 0, 0, 0, AluAdd, 0, 1, 0)));
        tick();
        EX_ready_i = 1'b0;
        present(32'h002081b3, 32'h118);
        sb.push_back(mk(32'h002081b3, 32'h118, 32'd0,
                        ctl(WbAlu, 0, 0, 0, 0, 1, AluAdd, 0, 0, 0)));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ((observe() !== sb[0]) || (ID_ready_o !== 1'b0)) begin
                failures++;
                $display("FAIL backpressure_hold[%0d]: got %h ready=%b required %h ready=0",
                         i, observe(), ID_ready_o, sb[0]);
            end
            tick();
        end
        EX_ready_i = 1'b1;
        @(negedge clk);
        checks++;
        exp_r = sb.pop_front(); got = observe();
        if (got !== exp_r) begin
            failures++; $display("FAIL backpressure_release: got %h required %h", got, exp_r);
        end
        tick();
        IF_valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (sb.size() == 0) begin
            failures++; $display("FAIL backpressure_next: scoreboard empty");
        end else begin
            exp_r = sb.pop_front(); got = observe();
            if (got !== exp_r) begin
                failures++; $display("FAIL backpressure_next: got %h required %h", got, exp_r);
            end
        end
    endtask

    task automatic test_illegal();
        tick();
        present(32'h0000007f, 32'h11c);
        exp_r = '0;
        exp_r.valid = 1'b1;
        exp_r.ctrl.illegal = 1'b1;
        exp_r.pc = 32'h11c;
        sb.push_back(exp_r);
        tick();
        IF_valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (sb.size() == 0) begin
            failures++; $display("FAIL illegal_payload: scoreboard empty");
        end else begin
            exp_r = sb.pop_front(); got = observe();
            if (got !== exp_r) begin
                failures++; $display("FAIL illegal_payload: got %h required %h", got, exp_r);
            end
        end
    endtask

    task automatic test_async_reset();
        tick();
        present(32'h002081b3, 32'h120);
        tick();
        IF_valid_i = 1'b0;
        EX_ready_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (observe() !== ex_rec_t'(0)) begin
            failures++; $display("FAIL async_reset_outputs: got %h required 0", observe());
        end
        checks++;
        if ({ID_stall_cnt_o, ID_flush_cnt_o} !== 64'd0) begin
            failures++; $display("FAIL async_reset_counters: got %h/%h required 0/0",
                                 ID_stall_cnt_o, ID_flush_cnt_o);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
        EX_ready_i = 1'b1;
        present(32'h002081b3, 32'h124);
        sb.push_back(mk(32'h002081b3, 32'h124, 32'd0,
                        ctl(WbAlu, 0, 0, 0, 0, 1, AluAdd, 0, 0, 0)));
        tick();
        IF_valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (sb.size() == 0) begin
            failures++; $display("FAIL regfile_cleared: scoreboard empty");
        end else begin
            exp_r = sb.pop_front(); got = observe();
            if (got !== exp_r) begin
                failures++; $display("FAIL regfile_cleared: got %h required %h", got, exp_r);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
        rst_n = 1'b0;
        IF_valid_i = 1'b0; IF_instruction_i = '0; IF_pc_i = '0;
        WB_we_i = 1'b0; WB_wr_addr_i = '0; WB_wr_data_i = '0;
        EX_flush_i = 1'b0; EX_ready_i = 1'b1;
        #1;
        test_reset();
        tick();
        rst_n = 1'b1;
        test_rtype();
        test_bypass();
        test_load_use();
        test_flush();
        test_backpressure();
        test_illegal();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            failures++; $display("FAIL scoreboard_drain: got %0d left required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
